// File: rtl/memblk_arb.sv
// Shared-memory tile: round-robin arbitrated ports into a fixed LAT-cycle pipe over a line/sideband store.
// Latency LAT from accept to rsp_valid; no response backpressure, one grant per cycle, never stalls.
module memblk_arb #(
  parameter int         NPORTS = 4,
  parameter int         ADDR_W = 10,
  parameter int         DATA_W = 528,
  parameter int         XW     = 4,
  parameter int         LAT    = 4,
  parameter logic [1:0] tileX  = 2'd0,
  parameter logic [1:0] tileY  = 2'd0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NPORTS-1:0]              req_valid,
  output logic [NPORTS-1:0]              req_ready,
  input  logic [NPORTS-1:0]              req_we,
  input  logic [NPORTS*(ADDR_W+4)-1:0]   req_addr,
  input  logic [NPORTS*DATA_W-1:0]       req_wdata,
  input  logic [NPORTS*XW-1:0]           req_xtra,
  output logic [NPORTS-1:0]              rsp_valid,
  output logic [NPORTS*DATA_W-1:0]       rsp_data,
  output logic [NPORTS*(XW+1)-1:0]       rsp_xtra,
  output logic [NPORTS-1:0]              rsp_err,
  output logic                           busy
);

  localparam int         AW      = ADDR_W + 4;
  localparam int         PW      = $clog2(NPORTS);
  localparam int         DEPTH   = 1 << ADDR_W;
  localparam logic [3:0] TILE_ID = {tileX, tileY};

  typedef struct packed {
    logic              vld;
    logic [PW-1:0]     port;
    logic              we;
    logic              err;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] wdata;
    logic [XW-1:0]     xtra;
    logic [DATA_W-1:0] rdata;
    logic              rflag;
  } pipe_t;

  pipe_t             pipe [1:LAT];
  pipe_t             s1_in;
  pipe_t             s2_in;

  logic [DATA_W-1:0] mem  [DEPTH];
  logic [XW-1:0]     tag  [DEPTH];
  logic [DEPTH-1:0]  flag;

  logic [PW-1:0]     ptr;
  logic [PW-1:0]     gnt_idx;
  logic [PW-1:0]     cand;
  logic              gnt_vld;
  logic [NPORTS-1:0] gnt;
  logic [AW-1:0]     g_addr;

  logic [DATA_W-1:0] fwd_data;
  logic              fwd_flag;

  logic [NPORTS-1:0] r_valid;
  logic [DATA_W-1:0] r_data;
  logic [XW:0]       r_xtra;
  logic              r_err;

  // Round-robin search starting at ptr; first requester wins.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NPORTS; k++) begin
      cand = PW'((int'(ptr) + k) % NPORTS);
      if (!gnt_vld && req_valid[cand]) begin
        gnt_vld    = 1'b1;
        gnt_idx    = cand;
        gnt[cand]  = 1'b1;
      end
    end
  end

  assign req_ready = gnt & {NPORTS{rst}};
  assign g_addr    = req_addr[gnt_idx*AW +: AW];

  always_comb begin
    s1_in       = '0;
    s1_in.vld   = gnt_vld;
    s1_in.port  = gnt_idx;
    s1_in.we    = req_we[gnt_idx];
    s1_in.err   = (g_addr[3:0] != TILE_ID);
    s1_in.idx   = g_addr[AW-1:4];
    s1_in.wdata = req_wdata[gnt_idx*DATA_W +: DATA_W];
    s1_in.xtra  = req_xtra[gnt_idx*XW +: XW];
  end

  // Store read at stage 1, overridden by the youngest older in-tile write still in flight.
  always_comb begin
    fwd_data = mem[pipe[1].idx];
    fwd_flag = flag[pipe[1].idx];
    for (int s = LAT; s >= 2; s--) begin
      if (pipe[s].vld && pipe[s].we && !pipe[s].err && (pipe[s].idx == pipe[1].idx)) begin
        fwd_data = pipe[s].wdata;
        fwd_flag = 1'b1;
      end
    end
  end

  always_comb begin
    s2_in = pipe[1];
    if (pipe[1].err) begin
      s2_in.rdata = '0;
      s2_in.rflag = 1'b0;
    end else if (pipe[1].we) begin
      s2_in.rdata = pipe[1].wdata;
      s2_in.rflag = 1'b1;
    end else begin
      s2_in.rdata = fwd_data;
      s2_in.rflag = fwd_flag;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
      for (int s = 1; s <= LAT; s++) pipe[s] <= '0;
    end else begin
      if (gnt_vld) ptr <= (gnt_idx == PW'(NPORTS-1)) ? '0 : gnt_idx + 1'b1;
      pipe[1] <= s1_in;
      pipe[2] <= s2_in;
      for (int s = 3; s <= LAT; s++) pipe[s] <= pipe[s-1];
    end
  end

  // Reads commit only their tag; line data is written by writes alone.
  always_ff @(posedge clk) begin
    if (pipe[LAT].vld && !pipe[LAT].err) begin
      if (pipe[LAT].we) mem[pipe[LAT].idx] <= pipe[LAT].wdata;
      tag[pipe[LAT].idx] <= pipe[LAT].xtra;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flag <= '0;
    end else if (pipe[LAT].vld && !pipe[LAT].err) begin
      flag[pipe[LAT].idx] <= pipe[LAT].rflag;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      r_data  <= '0;
      r_xtra  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= '0;
      if (pipe[LAT].vld) r_valid[pipe[LAT].port] <= 1'b1;
      r_data  <= pipe[LAT].rdata;
      r_xtra  <= pipe[LAT].err ? '0 : {pipe[LAT].xtra, pipe[LAT].rflag};
      r_err   <= pipe[LAT].err;
    end
  end

  assign rsp_valid = r_valid;
  assign rsp_err   = r_valid & {NPORTS{r_err}};

  for (genvar i = 0; i < NPORTS; i++) begin : g_rsp
    assign rsp_data[i*DATA_W +: DATA_W] = r_valid[i] ? r_data : '0;
    assign rsp_xtra[i*(XW+1) +: XW+1]   = r_valid[i] ? r_xtra : '0;
  end

  always_comb begin
    busy = 1'b0;
    for (int s = 1; s <= LAT; s++) busy = busy | pipe[s].vld;
  end

endmodule

// File: tb/tb_memblk_arb.sv
// Directed bench for memblk_arb with an accept-ordered scoreboard and reference line/flag model.
module tb_memblk_arb;
  localparam int         NP   = 4;
  localparam int         AWI  = 10;
  localparam int         AW   = AWI + 4;
  localparam int         DW   = 528;
  localparam int         XW   = 4;
  localparam int         LAT  = 4;
  localparam logic [3:0] TILE = 4'b0110;

  logic                clk = 1'b0;
  logic                rst;
  logic [NP-1:0]       req_valid;
  logic [NP-1:0]       req_ready;
  logic [NP-1:0]       req_we;
  logic [NP*AW-1:0]    req_addr;
  logic [NP*DW-1:0]    req_wdata;
  logic [NP*XW-1:0]    req_xtra;
  logic [NP-1:0]       rsp_valid;
  logic [NP*DW-1:0]    rsp_data;
  logic [NP*(XW+1)-1:0] rsp_xtra;
  logic [NP-1:0]       rsp_err;
  logic                busy;

  always #5 clk = ~clk;

  memblk_arb #(.NPORTS(NP), .ADDR_W(AWI), .DATA_W(DW), .XW(XW), .LAT(LAT),
               .tileX(2'd1), .tileY(2'd2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_xtra(req_xtra),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_xtra(rsp_xtra),
    .rsp_err(rsp_err), .busy(busy)
  );

  typedef struct {
    int            port;
    int            cyc;
    logic [DW-1:0] data;
    logic [XW:0]   xtra;
    logic          err;
    bit            chk_data;
  } exp_t;

  exp_t          sb [$];
  logic [DW-1:0] m_data [int];
  bit            m_flag [int];
  int            checks   = 0;
  int            failures = 0;
  int            cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Response monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1) begin
      for (int i = 0; i < NP; i++) begin
        if (rsp_valid[i]) begin
          checks++;
          assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL rsp_unexpected port=%0d observed=1 expected=0", i);
          end
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("rsp_port", i, e.port);
            chk("rsp_cycle", cyc, e.cyc);
            if (e.chk_data) chk("rsp_data", rsp_data[i*DW +: DW], e.data);
            chk("rsp_xtra", rsp_xtra[i*(XW+1) +: XW+1], e.xtra);
            chk("rsp_err", rsp_err[i], e.err);
          end
        end
      end
    end
  end

  task automatic drive(input int p, input bit we, input int idx, input logic [3:0] tl,
                       input logic [DW-1:0] d, input logic [XW-1:0] x);
    req_valid[p]          = 1'b1;
    req_we[p]             = we;
    req_addr[p*AW +: AW]  = {AWI'(idx), tl};
    req_wdata[p*DW +: DW] = d;
    req_xtra[p*XW +: XW]  = x;
  endtask

  task automatic accept(input int i);
    exp_t          e;
    logic [AW-1:0] a;
    int            idx;
    logic [DW-1:0] wd;
    logic [XW-1:0] x;
    a   = req_addr[i*AW +: AW];
    idx = int'(a[AW-1:4]);
    wd  = req_wdata[i*DW +: DW];
    x   = req_xtra[i*XW +: XW];
    e.port = i;
    e.cyc  = cyc + 1 + LAT;
    if (a[3:0] != TILE) begin
      e.data = '0; e.xtra = '0; e.err = 1'b1; e.chk_data = 1'b1;
    end else if (req_we[i]) begin
      e.data = wd; e.xtra = {x, 1'b1}; e.err = 1'b0; e.chk_data = 1'b1;
      m_data[idx] = wd;
      m_flag[idx] = 1'b1;
    end else begin
      e.chk_data = m_data.exists(idx);
      e.data     = e.chk_data ? m_data[idx] : '0;
      e.xtra     = {x, (m_flag.exists(idx) ? m_flag[idx] : 1'b0)};
      e.err      = 1'b0;
    end
    sb.push_back(e);
  endtask

  // One clock: record accepts just before the edge, retire accepted requests after it.
  task automatic tick(output logic [NP-1:0] rdy);
    #1;
    rdy = req_ready;
    for (int i = 0; i < NP; i++) if (req_valid[i] && req_ready[i]) accept(i);
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NP; i++) if (rdy[i]) req_valid[i] = 1'b0;
  endtask

  task automatic step();
    logic [NP-1:0] r;
    tick(r);
  endtask

  task automatic drain();
    for (int k = 0; k < LAT + 6 && sb.size() != 0; k++) step();
    #2;
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    logic [NP-1:0] r;
    logic [DW-1:0] da, db, dc;
    rst = 1'b0;
    req_valid = '1; req_we = '0; req_addr = '0; req_wdata = '0; req_xtra = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data[DW-1:0], 0);
    chk("rst_rsp_xtra", rsp_xtra, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_busy", busy, 0);

    // All ports requesting from reset: strict rotation 0,1,2,3,...
    for (int i = 0; i < NP; i++) drive(i, 1'b0, 30 + i, TILE, '0, XW'(i + 1));
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick(r);
      chk("rr_grant", r, NP'(1) << (k % NP));
      if (k == 0) chk("busy_active", busy, 1);
      drive(k % NP, 1'b0, 40 + k, TILE, '0, XW'(k));
    end
    req_valid = '0;
    drain();

    // Write then read after commit.
    drive(0, 1'b1, 5, TILE, {66{8'hA5}}, 4'd3);
    step();
    repeat (5) step();
    drive(1, 1'b0, 5, TILE, '0, 4'd3);
    step();
    drain();

    // Two writes and a read back-to-back: youngest write forwards.
    da = {66{8'h11}}; db = {66{8'h22}};
    drive(2, 1'b1, 7, TILE, da, 4'd5); step();
    drive(3, 1'b1, 7, TILE, db, 4'd6); step();
    drive(0, 1'b0, 7, TILE, '0, 4'd9); step();
    drain();
    drive(1, 1'b0, 7, TILE, '0, 4'd4); step();
    drain();

    // Read meeting the write at the last stage, then the first read served from the array.
    dc = {33{16'hBEEF}};
    drive(0, 1'b1, 12, TILE, dc, 4'd7); step();
    step(); step();
    drive(1, 1'b0, 12, TILE, '0, 4'd1); step();
    drive(2, 1'b0, 12, TILE, '0, 4'd2); step();
    drain();

    // Off-tile accesses error out and leave the line untouched.
    drive(3, 1'b1, 11, TILE, {66{8'h5A}}, 4'd2); step();
    drain();
    drive(0, 1'b0, 11, 4'b0001, '0, 4'd1); step();
    drive(1, 1'b1, 11, 4'b0001, {66{8'hC3}}, 4'd8); step();
    drive(2, 1'b0, 11, TILE, '0, 4'd5); step();
    drain();

    // Never-written line reports a clear written flag.
    drive(3, 1'b0, 9, TILE, '0, 4'd6); step();
    drain();

    // Reset with three requests in flight.
    drive(2, 1'b1, 20, TILE, {66{8'h77}}, 4'd1); step();
    drain();
    drive(3, 1'b1, 20, TILE, {66{8'h88}}, 4'd2); step();
    drive(0, 1'b1, 21, TILE, {66{8'h99}}, 4'd3); step();
    drive(1, 1'b0, 20, TILE, '0, 4'd4); step();
    rst = 1'b0;
    drive(0, 1'b0, 20, TILE, '0, 4'd0);
    #2;
    chk("midrst_busy", busy, 0);
    chk("midrst_req_ready", req_ready, 0);
    sb.delete();
    m_data[20] = {66{8'h77}};
    m_data.delete(21);
    m_flag.delete();
    for (int k = 0; k < LAT + 2; k++) begin
      @(negedge clk);
      chk("midrst_rsp_valid", rsp_valid, 0);
    end
    req_valid = '0;
    rst = 1'b1;
    // Pointer restarts at port 0 even though port 2 was next before reset.
    drive(2, 1'b0, 20, TILE, '0, 4'd7);
    drive(0, 1'b0, 21, TILE, '0, 4'd6);
    tick(r);
    chk("post_rst_grant0", r, 4'b0001);
    tick(r);
    chk("post_rst_grant1", r, 4'b0100);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/memblk_arb.md
# memblk_arb

Parametrised shared-memory tile block: NPORTS request ports are round-robin arbitrated into a single fixed-latency LAT-stage pipeline over a line store with a per-line sideband store. In-flight writes are forwarded to younger reads, so hazards never stall the pipeline. Requests not addressed to this tile complete with an error. Sits per tile between the port crossbar and the tile's memory array.

## Interface
Parameters:
- NPORTS, 4, number of request/response ports (≥2)
- ADDR_W, 10, line index width; the store holds 2^ADDR_W lines
- DATA_W, 528, line width (8×66)
- XW, 4, sideband tag width
- LAT, 4, request-to-response latency in cycles (≥2)
- tileX, 0, 2-bit tile X id
- tileY, 0, 2-bit tile Y id

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  NPORTS  per-port request valid
- req_ready  out  NPORTS  per-port grant; a request is accepted when valid&ready at a rising edge
- req_we  in  NPORTS  1=write, 0=read
- req_addr  in  NPORTS×(ADDR_W+4)  {line index, tileX[1:0], tileY[1:0]}
- req_wdata  in  NPORTS×DATA_W  write data
- req_xtra  in  NPORTS×XW  sideband tag stored on every accepted, in-tile access
- rsp_valid  out  NPORTS  one-cycle response strobe
- rsp_data  out  NPORTS×DATA_W  read data; echoed write data for writes
- rsp_xtra  out  NPORTS×(XW+1)  {stored tag, written flag} after the access
- rsp_err  out  NPORTS  tile-id mismatch
- busy  out  1  any pipeline stage valid

## Operation
- Arbiter: at most one grant per cycle. Search starts at priority pointer p; p resets to 0; after a grant to port i, p becomes (i+1) mod NPORTS. If no port requests, p holds. req_ready is combinational from req_valid and p.
- Tile check: low 4 address bits ≠ {tileX,tileY} sets err. An err request performs no store access and is never a forwarding source. It responds with rsp_data=0, rsp_xtra=0, rsp_err=1.
- Pipeline: stage s holds the request accepted s cycles earlier, s=1..LAT. Each entry carries port, we, index, wdata, xtra, err.
- Read at stage 1: the line and sideband are read from the store. If any non-err write to the same index sits in stages 2..LAT, the youngest such write (lowest stage) supplies both the data and {xtra,1} instead.
- Sideband update: the result for the access is {req_xtra, flag}. The flag is 1 for a write; for a read it is the read/forwarded flag. The read/forwarded flag and data travel down the pipe.
- Write commit: line and sideband are written at the end of stage LAT.
- Read sideband: the read's new tag is also committed at stage LAT. A read's commit does not overwrite a same-cycle or later write's data (tag store only).
- Sideband flag array resets to 0; line and tag contents are not reset.
- No backpressure on responses; the port must accept rsp_valid.

## Timing
- Accept at edge T → rsp_valid[port]=1 for exactly the cycle T+LAT..T+LAT+1, with data/xtra/err valid in that cycle.
- Throughput: one accepted request per cycle aggregate; never stalls.
- Write accepted at T is visible from the array to reads reaching stage 1 after T+LAT. Reads reaching stage 1 earlier get it by forwarding, including a write at stage LAT in the same cycle.
- Reset outputs: rsp_valid=0, rsp_data=0, rsp_xtra=0, rsp_err=0, busy=0. req_ready is combinational and is 0 while rst is low.
- Reset mid-operation: all in-flight entries are dropped with no response and no commit; p=0; flags clear.
- Simultaneous requests on all ports: exactly one grant; the others hold valid until granted; the worst-case wait is NPORTS-1 cycles.

## Test plan
Defaults NPORTS=4, LAT=4, tileX=1, tileY=2 (tile id 4'b0110).
- Write port0 idx 5 data 0xA5…, xtra 3 at T; read port1 idx 5 at T+6 → port1 rsp at T+10: data 0xA5…, rsp_xtra={3,1}, err 0.
- Back-to-back: write idx 7 data D1 at T, write idx 7 data D2 at T+1, read idx 7 at T+2 → read response D2 (youngest forward) at T+6; array holds D2 afterwards.
- All 4 ports valid continuously from reset → grants 0,1,2,3,0,… one per cycle; responses four cycles after each grant.
- Read with addr tile bits 4'b0001 → rsp_err=1, data 0 after 4 cycles; a subsequent in-tile read of the same index shows no change.
- Read of a never-written idx 9 after reset → rsp_xtra flag bit 0.
- Assert rst low with 3 requests in flight → no rsp_valid; busy=0; a later read shows no write committed.
